// File: rtl/sram_arbiter.sv
// Two-requester arbiter (CPU / video) in front of the single SRAM controller port.
// Define SRAM_ARB_RR_EN for round-robin contested arbitration instead of fixed CPU priority.
module sram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 48,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk_50mhz,
    input  logic              rstn,
    input  logic              r_stb,
    input  logic              r_we,
    input  logic [ADDR_W-1:0] r_addra,
    input  logic [DATA_W-1:0] r_dina,
    output logic [DATA_W-1:0] r_douta,
    output logic              r_ACK,
    input  logic              v_stb,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addra,
    input  logic [DATA_W-1:0] v_dina,
    output logic [DATA_W-1:0] v_douta,
    output logic              v_ACK,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addra,
    output logic [DATA_W-1:0] m_dina,
    input  logic [DATA_W-1:0] m_douta,
    input  logic              m_ack,
    output logic              err,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [9:0] TMO_LIM    = 10'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                m_stb_q, m_stb_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addra_q, m_addra_d;
    logic [DATA_W-1:0]   m_dina_q, m_dina_d;
    logic [DATA_W-1:0]   r_douta_q, r_douta_d;
    logic [DATA_W-1:0]   v_douta_q, v_douta_d;
    logic                r_ack_q, r_ack_d;
    logic                v_ack_q, v_ack_d;
    logic                err_q, err_d;
    logic                owner_q, owner_d;
    logic [7:0]          r_starve_q, r_starve_d;
    logic [7:0]          v_starve_q, v_starve_d;
    logic [9:0]          tmo_q, tmo_d;
    logic                win_v_s;
`ifdef SRAM_ARB_RR_EN
    logic                granted_q, granted_d;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt >= STARVE_LIM) begin
            return STARVE_LIM;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

    // Next-state, arbitration and output register updates
    always_comb begin
        state_d    = state_q;
        m_stb_d    = m_stb_q;
        m_we_d     = m_we_q;
        m_addra_d  = m_addra_q;
        m_dina_d   = m_dina_q;
        r_douta_d  = r_douta_q;
        v_douta_d  = v_douta_q;
        r_ack_d    = 1'b0;
        v_ack_d    = 1'b0;
        err_d      = 1'b0;
        owner_d    = owner_q;
        r_starve_d = r_starve_q;
        v_starve_d = v_starve_q;
        tmo_d      = tmo_q;
        win_v_s    = 1'b0;
`ifdef SRAM_ARB_RR_EN
        granted_d  = granted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (r_stb || v_stb) begin
                    if (r_stb && v_stb) begin
`ifdef SRAM_ARB_RR_EN
                        // Starved side is forced first; otherwise alternate, CPU first after reset.
                        if (v_starve_q == STARVE_LIM) begin
                            win_v_s = 1'b1;
                        end else if (r_starve_q == STARVE_LIM) begin
                            win_v_s = 1'b0;
                        end else if (granted_q) begin
                            win_v_s = ~owner_q;
                        end else begin
                            win_v_s = 1'b0;
                        end
`else
                        win_v_s = (v_starve_q == STARVE_LIM);
`endif
                    end else begin
                        win_v_s = v_stb;
                    end
                    if (win_v_s) begin
                        v_starve_d = 8'd0;
                        r_starve_d = r_stb ? sat_inc(r_starve_q) : r_starve_q;
                        m_we_d     = v_we;
                        m_addra_d  = v_addra;
                        m_dina_d   = v_dina;
                    end else begin
                        r_starve_d = 8'd0;
                        v_starve_d = v_stb ? sat_inc(v_starve_q) : v_starve_q;
                        m_we_d     = r_we;
                        m_addra_d  = r_addra;
                        m_dina_d   = r_dina;
                    end
                    owner_d = win_v_s;
                    m_stb_d = 1'b1;
                    tmo_d   = 10'd0;
                    state_d = ST_BUSY;
`ifdef SRAM_ARB_RR_EN
                    granted_d = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (m_ack) begin
                    if (owner_q) begin
                        v_douta_d = m_douta;
                        v_ack_d   = 1'b1;
                    end else begin
                        r_douta_d = m_douta;
                        r_ack_d   = 1'b1;
                    end
                    m_stb_d = 1'b0;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LIM) begin
                    // Abort: acknowledge the owner so it can retry, data is left untouched.
                    v_ack_d = owner_q;
                    r_ack_d = ~owner_q;
                    err_d   = 1'b1;
                    m_stb_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                m_stb_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            m_stb_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addra_q  <= '0;
            m_dina_q   <= '0;
            r_douta_q  <= '0;
            v_douta_q  <= '0;
            r_ack_q    <= 1'b0;
            v_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            owner_q    <= 1'b0;
            r_starve_q <= 8'd0;
            v_starve_q <= 8'd0;
            tmo_q      <= 10'd0;
`ifdef SRAM_ARB_RR_EN
            granted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            m_stb_q    <= m_stb_d;
            m_we_q     <= m_we_d;
            m_addra_q  <= m_addra_d;
            m_dina_q   <= m_dina_d;
            r_douta_q  <= r_douta_d;
            v_douta_q  <= v_douta_d;
            r_ack_q    <= r_ack_d;
            v_ack_q    <= v_ack_d;
            err_q      <= err_d;
            owner_q    <= owner_d;
            r_starve_q <= r_starve_d;
            v_starve_q <= v_starve_d;
            tmo_q      <= tmo_d;
`ifdef SRAM_ARB_RR_EN
            granted_q  <= granted_d;
`endif
        end
    end

    assign m_stb   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_addra = m_addra_q;
    assign m_dina  = m_dina_q;
    assign r_douta = r_douta_q;
    assign v_douta = v_douta_q;
    assign r_ACK   = r_ack_q;
    assign v_ACK   = v_ack_q;
    assign err     = err_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised self-checking bench for sram_arbiter against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 48;
    localparam int SM  = 8;
    localparam int TMO = 24;

    logic          clk_50mhz = 1'b0;
    logic          rstn = 1'b0;
    logic          r_stb = 1'b0, r_we = 1'b0, v_stb = 1'b0, v_we = 1'b0;
    logic [AW-1:0] r_addra = '0, v_addra = '0;
    logic [DW-1:0] r_dina = '0, v_dina = '0, m_douta = '0;
    logic          m_ack = 1'b0;
    logic [DW-1:0] r_douta, v_douta, m_dina;
    logic [AW-1:0] m_addra;
    logic          r_ACK, v_ACK, m_stb, m_we, err, owner;

    int checks = 0;
    int failures = 0;

    // model state
    int            r_cnt = 0, v_cnt = 0, last_win = 0;
    bit            have_grant = 1'b0;
    int            reissue_mode = 0;
    logic [DW-1:0] exp_r_dout = '0, exp_v_dout = '0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
        .clk_50mhz(clk_50mhz), .rstn(rstn),
        .r_stb(r_stb), .r_we(r_we), .r_addra(r_addra), .r_dina(r_dina),
        .r_douta(r_douta), .r_ACK(r_ACK),
        .v_stb(v_stb), .v_we(v_we), .v_addra(v_addra), .v_dina(v_dina),
        .v_douta(v_douta), .v_ACK(v_ACK),
        .m_stb(m_stb), .m_we(m_we), .m_addra(m_addra), .m_dina(m_dina),
        .m_douta(m_douta), .m_ack(m_ack), .err(err), .owner(owner)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic new_r_req();
        r_stb = 1'b1; r_we = 1'($urandom % 2); r_addra = AW'($urandom); r_dina = rnd_data();
    endtask

    task automatic new_v_req();
        v_stb = 1'b1; v_we = 1'($urandom % 2); v_addra = AW'($urandom); v_dina = rnd_data();
    endtask

    // contested winner straight from the arbitration rules
    function automatic int pick_contested();
`ifdef SRAM_ARB_RR_EN
        if (v_cnt == SM) return 1;
        if (r_cnt == SM) return 0;
        if (!have_grant) return 0;
        return 1 - last_win;
`else
        return (v_cnt == SM) ? 1 : 0;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rack"}, 64'(r_ACK), 64'(0));
        check_eq({tag, "_vack"}, 64'(v_ACK), 64'(0));
        check_eq({tag, "_err"}, 64'(err), 64'(0));
        check_eq({tag, "_mstb"}, 64'(m_stb), 64'(0));
        check_eq({tag, "_rdout"}, 64'(r_douta), 64'(exp_r_dout));
        check_eq({tag, "_vdout"}, 64'(v_douta), 64'(exp_v_dout));
    endtask

    // One IDLE slot; if anyone requests, run the whole transaction. ack_at = 0 withholds m_ack.
    task automatic run_slot(input int ack_at, input logic [DW-1:0] rdata, input bit idle_ack);
        int            win;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        bit            acked;
        m_ack   = idle_ack;
        m_douta = rnd_data();
        if (!r_stb && !v_stb) begin
            tick();
            m_ack = 1'b0;
            check_quiet("idle");
            return;
        end
        if (r_stb && v_stb) win = pick_contested();
        else win = v_stb ? 1 : 0;
        if (win == 1) begin
            v_cnt = 0;
            if (r_stb) r_cnt = (r_cnt + 1 > SM) ? SM : r_cnt + 1;
            e_we = v_we; e_addr = v_addra; e_din = v_dina;
        end else begin
            r_cnt = 0;
            if (v_stb) v_cnt = (v_cnt + 1 > SM) ? SM : v_cnt + 1;
            e_we = r_we; e_addr = r_addra; e_din = r_dina;
        end
        tick();
        m_ack = 1'b0;
        check_eq("grant_mstb", 64'(m_stb), 64'(1));
        check_eq("grant_owner", 64'(owner), 64'(win));
        check_eq("grant_we", 64'(m_we), 64'(e_we));
        check_eq("grant_addr", 64'(m_addra), 64'(e_addr));
        check_eq("grant_din", 64'(m_dina), 64'(e_din));
        check_eq("grant_noack", 64'(r_ACK | v_ACK), 64'(0));
        for (int k = 1; k <= TMO; k++) begin
            acked   = (k == ack_at);
            m_ack   = acked;
            m_douta = acked ? rdata : rnd_data();
            tick();
            m_ack = 1'b0;
            if (acked || k == TMO) begin
                if (acked && win == 1) exp_v_dout = rdata;
                if (acked && win == 0) exp_r_dout = rdata;
                check_eq("done_rack", 64'(r_ACK), 64'(win == 0));
                check_eq("done_vack", 64'(v_ACK), 64'(win == 1));
                check_eq("done_err", 64'(err), 64'(!acked));
                check_eq("done_mstb", 64'(m_stb), 64'(0));
                check_eq("done_rdout", 64'(r_douta), 64'(exp_r_dout));
                check_eq("done_vdout", 64'(v_douta), 64'(exp_v_dout));
                break;
            end else begin
                check_eq("busy_mstb", 64'(m_stb), 64'(1));
                check_eq("busy_addr", 64'(m_addra), 64'(e_addr));
                check_eq("busy_din", 64'(m_dina), 64'(e_din));
                check_eq("busy_ack", 64'({r_ACK, v_ACK, err}), 64'(0));
            end
        end
        if (reissue_mode == 0 || (reissue_mode == 2 && ($urandom % 2) == 0)) begin
            if (win == 1) v_stb = 1'b0; else r_stb = 1'b0;
        end else if (reissue_mode == 2) begin
            if (win == 1) new_v_req(); else new_r_req();
        end
        // DONE bubble, with a stale m_ack that must be ignored
        m_ack   = 1'($urandom % 2);
        m_douta = rnd_data();
        tick();
        m_ack = 1'b0;
        check_quiet("bubble");
        last_win   = win;
        have_grant = 1'b1;
    endtask

    initial begin
        int exp_win;
        #35;
        check_eq("rst_mstb", 64'(m_stb), 64'(0));
        check_eq("rst_owner", 64'(owner), 64'(0));
        check_eq("rst_outs", 64'({r_ACK, v_ACK, err, m_we}), 64'(0));
        check_eq("rst_addr", 64'(m_addra), 64'(0));
        rstn = 1'b1;
        tick();

        // CPU read alone
        r_stb = 1'b1; r_we = 1'b0; r_addra = 20'h00010; r_dina = 48'h0;
        reissue_mode = 0;
        run_slot(1, 48'h123456789ABC, 1'b0);
        check_eq("cpu_read_data", 64'(r_douta), 64'(48'h123456789ABC));

        // both requesters held continuously
        new_r_req(); new_v_req();
        reissue_mode = 1;
        for (int i = 0; i < 27; i++) begin
            run_slot(1, rnd_data(), 1'b0);
`ifdef SRAM_ARB_RR_EN
            exp_win = (i % 2 == 0) ? 1 : 0;
`else
            exp_win = (i % 9 == 8) ? 1 : 0;
`endif
            check_eq("rotation", 64'(last_win), 64'(exp_win));
        end

        // video write with m_ack withheld, then an immediate CPU read
        r_stb = 1'b0;
        v_stb = 1'b1; v_we = 1'b1; v_addra = 20'h80005; v_dina = 48'h000008080000;
        reissue_mode = 0;
        run_slot(0, 48'h0, 1'b0);
        new_r_req();
        run_slot(2, rnd_data(), 1'b1);

        // reset during BUSY, stale m_ack after release
        r_stb = 1'b1; r_we = 1'b0; r_addra = 20'h00abc;
        tick();
        check_eq("pre_rst_mstb", 64'(m_stb), 64'(1));
        tick();
        #3 rstn = 1'b0;
        #1;
        check_eq("mid_rst_mstb", 64'(m_stb), 64'(0));
        check_eq("mid_rst_outs", 64'({r_ACK, v_ACK, err, owner, m_we}), 64'(0));
        check_eq("mid_rst_addr", 64'(m_addra), 64'(0));
        check_eq("mid_rst_din", 64'(m_dina), 64'(0));
        check_eq("mid_rst_rdout", 64'(r_douta), 64'(0));
        check_eq("mid_rst_vdout", 64'(v_douta), 64'(0));
        r_stb = 1'b0;
        r_cnt = 0; v_cnt = 0; last_win = 0; have_grant = 1'b0;
        exp_r_dout = '0; exp_v_dout = '0;
        tick();
        rstn = 1'b1;
        tick();
        m_ack = 1'b1; m_douta = rnd_data();
        tick();
        m_ack = 1'b0;
        check_quiet("post_rst");

        // randomised traffic
        reissue_mode = 2;
        for (int i = 0; i < 150; i++) begin
            int ack_at;
            if (!r_stb && ($urandom % 10) < 6) new_r_req();
            if (!v_stb && ($urandom % 10) < 6) new_v_req();
            ack_at = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 6));
            run_slot(ack_at, rnd_data(), 1'(($urandom % 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
